// File: rtl/spike_dispatcher.sv
// spike_dispatcher
//
// Buffers incoming spike source addresses in a small FIFO and feeds them to a
// level-sensitive MAC array. Addresses are released one at a time, only in
// even dispatch slots of a timestep, so that an idle address always separates
// two dispatched spikes. This lets the MAC see every address change, even when
// the same address arrives twice in a row.
//
// The last cycle of every timestep is a boundary cycle: no pop happens in it.
// The cycle after it shows clear/done. Every output comes straight from a flop.
// The outputs in any cycle are therefore the registered result of the
// previous cycle's slot decision.
//
// Parameters
//   FIFO_DEPTH      spike queue depth (power of 2, 2..64)
//   TIMESTEP_CYCLES timestep length in clocks (>= 2), matches the MAC timestep
//   IDLE_ADDR       address driven when no spike is dispatched
//
// Ports
//   CLK_Mac         single clock
//   RST             synchronous active-high reset
//   en              run enable; low freezes the timestep counter and read side
//   in_addr         incoming spike source address
//   in_valid        in_addr valid
//   in_ready        queue can accept (registered, from current occupancy)
//   source_address  address to the MAC (IDLE_ADDR when nothing is dispatched)
//   src_valid       source_address carries a real spike this cycle
//   clear           timestep boundary pulse to the MAC
//   done            copy of clear for the neuron stage
//   fifo_level      current queue occupancy
//   spike_count     (only with SPIKE_DISPATCHER_STATS_EN) dispatches counted
//                   in the last completed timestep, saturating at 16'hFFFF
//
// Optional feature macro: SPIKE_DISPATCHER_STATS_EN

module spike_dispatcher #(
   parameter int          FIFO_DEPTH      = 8,
   parameter int          TIMESTEP_CYCLES = 4,
   parameter logic [11:0] IDLE_ADDR       = 12'hFFF
) (
   input  logic                          CLK_Mac,
   input  logic                          RST,
   input  logic                          en,
   input  logic [11:0]                   in_addr,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [11:0]                   source_address,
   output logic                          src_valid,
   output logic                          clear,
   output logic                          done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SPIKE_DISPATCHER_STATS_EN
   ,
   output logic [15:0]                   spike_count
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int TW = $clog2(TIMESTEP_CYCLES);

   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TS_LAST    = TW'(TIMESTEP_CYCLES - 1);

   logic [11:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [TW-1:0] ts_cnt;
   logic [LW-1:0] level_next;

   logic push;
   logic pop;
   logic boundary;

   // Slot decoding. Only even slots may pop. Between two pops there is then
   // always an odd slot or the boundary cycle, so the MAC gets an idle address
   // between spikes. Push looks at the registered in_ready, so a pop in the
   // same cycle never makes room for that push.
   always_comb begin
      push     = in_valid && in_ready;
      boundary = en && (ts_cnt == TS_LAST);
      pop      = en && (ts_cnt != TS_LAST) && !ts_cnt[0] && (fifo_level != '0);
   end

   // Occupancy after this edge. A push and a pop together cancel out.
   always_comb begin
      level_next = fifo_level;
      case ({push, pop})
         2'b10:   level_next = fifo_level + 1'b1;
         2'b01:   level_next = fifo_level - 1'b1;
         default: level_next = fifo_level;
      endcase
   end

   // Queue storage. It has no reset because entries are only read once the
   // level says they hold data.
   always_ff @(posedge CLK_Mac) begin
      if (push) begin
         mem[wr_ptr] <= in_addr;
      end
   end

   // Queue pointers, level and ready flag. The pointers wrap for free because
   // the depth is a power of two. in_ready tracks the level that will be
   // visible next cycle, so it stays a pure flop output.
   always_ff @(posedge CLK_Mac) begin
      if (RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         in_ready   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_level <= level_next;
         in_ready   <= (level_next < LEVEL_FULL);
      end
   end

   // Timestep counter and MAC-side outputs. When en is low the counter holds
   // and the outputs drop to idle. A spike cannot sit on the MAC across a
   // stall, and the even-slot rule still keeps spikes apart on resume.
   always_ff @(posedge CLK_Mac) begin
      if (RST) begin
         ts_cnt         <= '0;
         source_address <= IDLE_ADDR;
         src_valid      <= 1'b0;
         clear          <= 1'b0;
         done           <= 1'b0;
      end else begin
         if (en) begin
            ts_cnt <= boundary ? '0 : ts_cnt + 1'b1;
         end
         source_address <= pop ? mem[rd_ptr] : IDLE_ADDR;
         src_valid      <= pop;
         clear          <= boundary;
         done           <= boundary;
      end
   end

`ifdef SPIKE_DISPATCHER_STATS_EN
   logic [15:0] spike_acc;

   // Per-timestep dispatch statistics. The running count goes into the
   // holding register on the boundary cycle and then restarts. A boundary
   // cycle never pops, so the count and the capture never collide.
   always_ff @(posedge CLK_Mac) begin
      if (RST) begin
         spike_acc   <= '0;
         spike_count <= '0;
      end else if (boundary) begin
         spike_count <= spike_acc;
         spike_acc   <= '0;
      end else if (pop && (spike_acc != 16'hFFFF)) begin
         spike_acc <= spike_acc + 1'b1;
      end
   end
`endif

endmodule
